// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, redirect and IRQ/exception sequencer
// Owns EPC and a saturating load-use stall counter; all steering outputs are combinational.
module pipe_hazard_ctrl #(
  parameter logic [31:0] IRQ_VEC = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC = 32'h8000_0008,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_tgt,
  input  logic             id_illop,
  input  logic             ex_memread,
  input  logic [4:0]       ex_dst,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_tgt,
  input  logic             irq,
  output logic             pc_write,
  output logic             if2id_en,
  output logic             if2id_flush,
  output logic             id2ex_flush,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic             irq_ack,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ENTER, S_KERNEL} state_t;

  state_t state, state_nxt;
  logic   load_use;
  logic   user_pc;
  logic   exc_take;
  logic   irq_take;
  logic   stall_take;

  assign user_pc  = ~id_pc[31];
  assign load_use = ex_memread && (ex_dst != 5'd0) &&
                    ((id_uses_rs && (ex_dst == id_rs)) || (id_uses_rt && (ex_dst == id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Entry from WAIT needs a real, right-path, user-mode instruction in ID to become EPC.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (irq && user_pc) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!irq)
          state_nxt = S_RUN;
        else if (id_valid && !ex_br_taken && !load_use && user_pc)
          state_nxt = S_ENTER;
      end
      S_ENTER:  state_nxt = S_KERNEL;
      S_KERNEL: if (id_valid && user_pc) state_nxt = S_RUN;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    if2id_en    = 1'b1;
    if2id_flush = 1'b0;
    id2ex_flush = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    irq_ack     = 1'b0;
    exc_take    = 1'b0;
    irq_take    = 1'b0;
    stall_take  = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      if2id_en    = 1'b0;
      if2id_flush = 1'b1;
      id2ex_flush = 1'b1;
    end else if (ex_br_taken) begin
      redirect    = 1'b1;
      redirect_pc = ex_br_tgt;
      if2id_flush = 1'b1;
      id2ex_flush = 1'b1;
    end else if (state == S_RUN && id_valid && id_illop && user_pc) begin
      exc_take    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = EXC_VEC;
      if2id_flush = 1'b1;
      id2ex_flush = 1'b1;
    end else if (state == S_ENTER) begin
      irq_take    = 1'b1;
      irq_ack     = 1'b1;
      redirect    = 1'b1;
      redirect_pc = IRQ_VEC;
      if2id_flush = 1'b1;
      id2ex_flush = 1'b1;
    end else if (load_use) begin
      // A jr caught here re-presents after the bubble and redirects then.
      stall_take  = 1'b1;
      pc_write    = 1'b0;
      if2id_en    = 1'b0;
      id2ex_flush = 1'b1;
    end else if (id_jump && id_valid) begin
      redirect    = 1'b1;
      redirect_pc = id_jump_tgt;
      if2id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc       <= 32'h0;
      stall_cnt <= '0;
    end else begin
      if (exc_take || irq_take)
        epc <= id_pc;
      if (stall_take && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with a behavioural model
// Narrow stall counter so saturation is reached within the random run.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  typedef struct {
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_jump;
    logic [31:0] id_jump_tgt;
    logic        id_illop;
    logic        ex_memread;
    logic [4:0]  ex_dst;
    logic        ex_br_taken;
    logic [31:0] ex_br_tgt;
    logic        irq;
  } vec_t;

  typedef struct {
    logic          pc_write;
    logic          if2id_en;
    logic          if2id_flush;
    logic          id2ex_flush;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   epc;
    logic          irq_ack;
    logic [CW-1:0] stall_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_jump = 1'b0, id_illop = 1'b0;
  logic ex_memread = 1'b0, ex_br_taken = 1'b0, irq = 1'b0;
  logic [31:0] id_pc = '0, id_jump_tgt = '0, ex_br_tgt = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_dst = '0;
  logic pc_write, if2id_en, if2id_flush, id2ex_flush, redirect, irq_ack;
  logic [31:0] redirect_pc, epc;
  logic [CW-1:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .id_jump_tgt(id_jump_tgt), .id_illop(id_illop), .ex_memread(ex_memread),
    .ex_dst(ex_dst), .ex_br_taken(ex_br_taken), .ex_br_tgt(ex_br_tgt), .irq(irq),
    .pc_write(pc_write), .if2id_en(if2id_en), .if2id_flush(if2id_flush),
    .id2ex_flush(id2ex_flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .epc(epc), .irq_ack(irq_ack), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: interrupt progress as flags, not an encoded state.
  bit          m_pending, m_entering, m_in_kernel;
  logic [31:0] m_epc;
  int          m_cnt;

  function automatic exp_t model_step(input vec_t v);
    exp_t e;
    bit lu, user;
    e = '{pc_write: 1'b1, if2id_en: 1'b1, if2id_flush: 1'b0, id2ex_flush: 1'b0,
          redirect: 1'b0, redirect_pc: 32'h0, epc: m_epc, irq_ack: 1'b0,
          stall_cnt: CW'(m_cnt)};
    if (v.rst) begin
      e = '{pc_write: 1'b0, if2id_en: 1'b0, if2id_flush: 1'b1, id2ex_flush: 1'b1,
            redirect: 1'b0, redirect_pc: 32'h0, epc: 32'h0, irq_ack: 1'b0, stall_cnt: '0};
      m_pending = 0; m_entering = 0; m_in_kernel = 0; m_epc = 0; m_cnt = 0;
      return e;
    end
    user = (v.id_pc >= 32'h8000_0000) ? 1'b0 : 1'b1;
    lu = v.ex_memread && v.ex_dst != 0 &&
         ((v.id_uses_rs && v.ex_dst == v.id_rs) || (v.id_uses_rt && v.ex_dst == v.id_rt));
    if (v.ex_br_taken) begin
      e.redirect = 1; e.redirect_pc = v.ex_br_tgt; e.if2id_flush = 1; e.id2ex_flush = 1;
    end else if (!m_pending && !m_entering && !m_in_kernel && v.id_valid && v.id_illop && user) begin
      e.redirect = 1; e.redirect_pc = 32'h8000_0008; e.if2id_flush = 1; e.id2ex_flush = 1;
      m_epc = v.id_pc;
    end else if (m_entering) begin
      e.redirect = 1; e.redirect_pc = 32'h8000_0004; e.if2id_flush = 1; e.id2ex_flush = 1;
      e.irq_ack = 1; m_epc = v.id_pc;
    end else if (lu) begin
      e.pc_write = 0; e.if2id_en = 0; e.id2ex_flush = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (v.id_jump && v.id_valid) begin
      e.redirect = 1; e.redirect_pc = v.id_jump_tgt; e.if2id_flush = 1;
    end
    if (m_entering) begin
      m_entering = 0; m_in_kernel = 1;
    end else if (m_in_kernel) begin
      if (v.id_valid && user) m_in_kernel = 0;
    end else if (m_pending) begin
      if (!v.irq) m_pending = 0;
      else if (v.id_valid && !v.ex_br_taken && !lu && user) begin
        m_pending = 0; m_entering = 1;
      end
    end else if (v.irq && user) begin
      m_pending = 1;
    end
    return e;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = '{rst: 1'b0, id_valid: 1'b1, id_pc: 32'h0000_1000, id_rs: 5'd0, id_rt: 5'd0,
          id_uses_rs: 1'b0, id_uses_rt: 1'b0, id_jump: 1'b0, id_jump_tgt: 32'h0,
          id_illop: 1'b0, ex_memread: 1'b0, ex_dst: 5'd0, ex_br_taken: 1'b0,
          ex_br_tgt: 32'h0, irq: 1'b0};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; id_valid = v.id_valid; id_pc = v.id_pc; id_rs = v.id_rs; id_rt = v.id_rt;
    id_uses_rs = v.id_uses_rs; id_uses_rt = v.id_uses_rt; id_jump = v.id_jump;
    id_jump_tgt = v.id_jump_tgt; id_illop = v.id_illop; ex_memread = v.ex_memread;
    ex_dst = v.ex_dst; ex_br_taken = v.ex_br_taken; ex_br_tgt = v.ex_br_tgt; irq = v.irq;
    exp_q.push_back(model_step(v));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_write",    32'(pc_write),    32'(e.pc_write));
        chk("if2id_en",    32'(if2id_en),    32'(e.if2id_en));
        chk("if2id_flush", 32'(if2id_flush), 32'(e.if2id_flush));
        chk("id2ex_flush", 32'(id2ex_flush), 32'(e.id2ex_flush));
        chk("redirect",    32'(redirect),    32'(e.redirect));
        chk("redirect_pc", redirect_pc,      e.redirect_pc);
        chk("epc",         epc,              e.epc);
        chk("irq_ack",     32'(irq_ack),     32'(e.irq_ack));
        chk("stall_cnt",   32'(stall_cnt),   32'(e.stall_cnt));
      end
    end
  end

  initial begin : stim
    vec_t v;
    int   drain;
    v = idle(); v.rst = 1; apply(v); apply(v);
    apply(idle());
    // Load-use, then $0 destination and unused-rt matches.
    v = idle(); v.ex_memread = 1; v.ex_dst = 5; v.id_rs = 5; v.id_uses_rs = 1; apply(v);
    apply(idle());
    v = idle(); v.ex_memread = 1; v.ex_dst = 0; v.id_rs = 0; v.id_uses_rs = 1; apply(v);
    v = idle(); v.ex_memread = 1; v.ex_dst = 7; v.id_rt = 7; v.id_uses_rt = 0; apply(v);
    // Branch beats a jump in ID.
    v = idle(); v.ex_br_taken = 1; v.ex_br_tgt = 32'h40; v.id_jump = 1; v.id_jump_tgt = 32'h99; apply(v);
    v = idle(); v.id_jump = 1; v.id_jump_tgt = 32'h0000_0300; apply(v);
    // IRQ entry, then irq held in kernel with no re-entry.
    v = idle(); v.irq = 1; v.id_pc = 32'h100; apply(v); apply(v); apply(v);
    v.id_pc = 32'h8000_0004; repeat (4) apply(v);
    v = idle(); apply(v); apply(v);
    // IRQ waiting while a branch and then a bubble go by.
    v = idle(); v.irq = 1; v.id_pc = 32'h180; apply(v);
    v.ex_br_taken = 1; v.ex_br_tgt = 32'h44; apply(v);
    v.ex_br_taken = 0; v.id_valid = 0; apply(v);
    v.id_valid = 1; apply(v); apply(v);
    v = idle(); v.id_pc = 32'h8000_0010; apply(v);
    v = idle(); apply(v);
    // Illegal op, then reset in the middle of an IRQ sequence.
    v = idle(); v.id_illop = 1; v.id_pc = 32'h200; v.irq = 1; apply(v);
    v = idle(); v.id_pc = 32'h8000_0008; v.irq = 1; apply(v);
    v.id_pc = 32'h204; apply(v);
    v.rst = 1; apply(v);
    v = idle(); apply(v); apply(v);
    // Random traffic with a sticky irq level and rare resets.
    for (int n = 0; n < 3000; n++) begin
      v = idle();
      v.rst         = ($urandom_range(0, 299) == 0);
      v.id_valid    = ($urandom_range(0, 9) != 0);
      v.id_pc       = $urandom() & 32'hffff_fffc;
      v.id_pc[31]   = ($urandom_range(0, 3) == 0);
      v.id_rs       = 5'($urandom_range(0, 3));
      v.id_rt       = 5'($urandom_range(0, 3));
      v.id_uses_rs  = 1'($urandom_range(0, 1));
      v.id_uses_rt  = 1'($urandom_range(0, 1));
      v.id_jump     = ($urandom_range(0, 5) == 0);
      v.id_jump_tgt = $urandom();
      v.id_illop    = ($urandom_range(0, 9) == 0);
      v.ex_memread  = ($urandom_range(0, 2) == 0);
      v.ex_dst      = 5'($urandom_range(0, 3));
      v.ex_br_taken = ($urandom_range(0, 7) == 0);
      v.ex_br_tgt   = $urandom();
      v.irq         = ($urandom_range(0, 9) == 0) ? ~irq : irq;
      apply(v);
    end
    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
